result_demux: RTL and testbench

Two-entry buffered result demultiplexer for the CPU datapath. It accepts one result word tagged with a 3-bit destination flag and delivers it to exactly one of five sinks, numbered 0–4. The flag encoding matches the datapath select flags (0 = a … 4 = e). Both the producer side and each sink side use a valid/ready handshake. Malformed flags (5–7) are consumed, dropped and counted.

---
 rtl/result_demux.sv | 94 +++++++++
 tb/tb_result_demux.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/result_demux.sv
// Two-entry buffered result demultiplexer: routes each flagged result word to one of five sinks.
// Words with flags 5-7 are consumed, dropped, flagged on err and counted in drop_cnt.
module result_demux #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_flag,
   input  logic [WIDTH-1:0] in_data,
   output logic [4:0]       out_valid,
   input  logic [4:0]       out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             err,
   output logic [7:0]       drop_cnt
);

   logic [2:0]       flag_q [2];
   logic [WIDTH-1:0] data_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       count_q, count_d;
   logic             err_q;
   logic [7:0]       drop_cnt_q;

   logic             accept, legal, push, drop, pop;
   logic [2:0]       head_flag;

   // in_ready depends on registered state only, never on out_ready or in_valid
   assign in_ready  = (count_q != 2'd2);
   assign accept    = in_valid & in_ready;
   assign legal     = (in_flag <= 3'd4);
   assign push      = accept & legal;
   assign drop      = accept & ~legal;
   assign head_flag = flag_q[rd_ptr_q];
   assign out_data  = data_q[rd_ptr_q];
   assign err       = err_q;
   assign drop_cnt  = drop_cnt_q;

   always_comb begin
      out_valid = 5'b00000;
      if (count_q != 2'd0) begin
         case (head_flag)
            3'd0:    out_valid = 5'b00001;
            3'd1:    out_valid = 5'b00010;
            3'd2:    out_valid = 5'b00100;
            3'd3:    out_valid = 5'b01000;
            3'd4:    out_valid = 5'b10000;
            default: out_valid = 5'b00000;
         endcase
      end
   end

   // Only the sink addressed by the head word can pop it
   assign pop = |(out_valid & out_ready);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q[0]  <= 3'd0;
         flag_q[1]  <= 3'd0;
         data_q[0]  <= '0;
         data_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         err_q      <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         if (push) begin
            flag_q[wr_ptr_q] <= in_flag;
            data_q[wr_ptr_q] <= in_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
         err_q   <= drop;
         if (drop && (drop_cnt_q != 8'hff)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_result_demux.sv
// Directed-vector bench for result_demux with hand-computed expected values.
module tb_result_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_flag;
   logic [31:0] in_data;
   logic [4:0]  out_valid;
   logic [4:0]  out_ready;
   logic [31:0] out_data;
   logic        err;
   logic [7:0]  drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   result_demux #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_flag   (in_flag),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 2 time units after it
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [4:0] onehot(input int f);
      logic [4:0] v;
      v = 5'b00001 << f;
      return v;
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_flag   = 3'd0;
      in_data   = 32'h0;
      out_ready = 5'b00000;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset then idle
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

      // Single word, all sinks ready
      out_ready = 5'b11111;
      in_valid  = 1'b1;
      in_flag   = 3'd2;
      in_data   = 32'hDEADBEEF;
      step();
      in_valid = 1'b0;
      check("single_valid", 32'(out_valid), 32'b00100);
      check("single_data", out_data, 32'hDEADBEEF);
      step();
      check("single_gone", 32'(out_valid), 32'd0);

      // Backpressure with head-of-line blocking
      out_ready = 5'b00000;
      in_valid  = 1'b1;
      in_flag   = 3'd0;
      in_data   = 32'hA0;
      step();
      in_flag = 3'd4;
      in_data = 32'hA4;
      step();
      in_valid = 1'b0;
      check("bp_full_ready", 32'(in_ready), 32'd0);
      check("bp_head_valid", 32'(out_valid), 32'b00001);
      check("bp_head_data", out_data, 32'hA0);
      out_ready = 5'b10000;
      step();
      check("bp_hol_valid", 32'(out_valid), 32'b00001);
      check("bp_hol_ready", 32'(in_ready), 32'd0);
      out_ready = 5'b00001;
      step();
      check("bp_second_valid", 32'(out_valid), 32'b10000);
      check("bp_second_data", out_data, 32'hA4);
      check("bp_after_pop_ready", 32'(in_ready), 32'd1);
      out_ready = 5'b10000;
      step();
      check("bp_drained", 32'(out_valid), 32'd0);

      // Streaming, one word per cycle
      out_ready = 5'b11111;
      for (int i = 0; i <= 10; i++) begin
         if (i < 10) begin
            in_valid = 1'b1;
            in_flag  = 3'(i % 5);
            in_data  = 32'h100 + 32'(i);
         end else begin
            in_valid = 1'b0;
         end
         check("stream_in_ready", 32'(in_ready), 32'd1);
         if (i > 0) begin
            check("stream_valid", 32'(out_valid), 32'(onehot((i - 1) % 5)));
            check("stream_data", out_data, 32'h100 + 32'(i - 1));
         end
         step();
      end
      check("stream_drained", 32'(out_valid), 32'd0);

      // Illegal flags
      in_valid = 1'b1;
      in_flag  = 3'd6;
      in_data  = 32'h66;
      step();
      check("ill_err_1", 32'(err), 32'd1);
      check("ill_cnt_1", 32'(drop_cnt), 32'd1);
      check("ill_no_valid_1", 32'(out_valid), 32'd0);
      in_flag = 3'd7;
      in_data = 32'h77;
      step();
      check("ill_err_2", 32'(err), 32'd1);
      check("ill_cnt_2", 32'(drop_cnt), 32'd2);
      in_flag = 3'd1;
      in_data = 32'h11;
      step();
      in_valid = 1'b0;
      check("ill_err_clear", 32'(err), 32'd0);
      check("ill_cnt_hold", 32'(drop_cnt), 32'd2);
      check("ill_legal_valid", 32'(out_valid), 32'b00010);
      check("ill_legal_data", out_data, 32'h11);
      step();
      check("ill_drained", 32'(out_valid), 32'd0);

      // Saturation over 300 illegal pushes
      in_valid = 1'b1;
      in_flag  = 3'd5;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (i == 100) check("sat_cnt_mid", 32'(drop_cnt), 32'd102);
         if (i == 253) check("sat_cnt_reach", 32'(drop_cnt), 32'd255);
      end
      in_valid = 1'b0;
      check("sat_cnt_final", 32'(drop_cnt), 32'd255);
      check("sat_err_held", 32'(err), 32'd1);
      step();
      check("sat_err_clear", 32'(err), 32'd0);

      // Fill, then an illegal word while full must not be accepted
      out_ready = 5'b00000;
      in_valid  = 1'b1;
      in_flag   = 3'd3;
      in_data   = 32'h33;
      step();
      in_data = 32'h34;
      step();
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_valid", 32'(out_valid), 32'b01000);
      in_flag = 3'd7;
      step();
      check("full_ill_no_err", 32'(err), 32'd0);
      check("full_ill_valid", 32'(out_valid), 32'b01000);

      // Reset mid-stream with the FIFO full; no handshake during reset
      rst     = 1'b1;
      in_flag = 3'd1;
      in_data = 32'h55;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_cnt", 32'(drop_cnt), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      step();
      check("mid_rst_nothing", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
